// File: rtl/ttc_apb_sched18_pkg.sv
// Shared definitions for the ttc_apb_sched18 APB sequencer: FSM encoding, address defaults, field widths.
// Build option TTC_SCHED_RR_EN (see ttc_sched_pick18) selects round-robin timer selection.
package ttc_apb_sched18_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2,
      ST_DONE   = 2'd3
   } sched_state_t;

   localparam logic [7:0] ISR_BASE_DEF   = 8'h54;
   localparam logic [7:0] ISR_STRIDE_DEF = 8'h04;
   localparam int         HOLDOFF_DEF    = 2;

   localparam int ADDR_W   = 8;
   localparam int DATA_W   = 32;
   localparam int STATUS_W = 6;
   localparam int HOLD_W   = 3;

   // Timer n (1..3) interrupt register lives at base + (n-1)*stride.
   function automatic logic [ADDR_W-1:0] isr_addr(input logic [ADDR_W-1:0] base,
                                                   input logic [ADDR_W-1:0] stride,
                                                   input logic [1:0]        n);
      logic [ADDR_W-1:0] idx;
      idx = {6'd0, n} - 8'd1;
      return base + idx * stride;
   endfunction

endpackage

// File: rtl/ttc_apb_sched18_pick.sv
// Timer selector for ttc_apb_sched18: lowest eligible index, or round-robin from ptr
// when TTC_SCHED_RR_EN is defined.
module ttc_sched_pick18
   import ttc_apb_sched18_pkg::*;
(
   input  logic [3:1] eligible,
   input  logic [1:0] ptr,
   output logic       valid,
   output logic [1:0] index
);

`ifdef TTC_SCHED_RR_EN
   // Candidate k steps after ptr, wrapping 3 -> 1.
   function automatic logic [1:0] rr_idx(input logic [1:0] p, input int k);
      int c;
      c = ((p == 2'd0) ? 1 : int'(p)) + k;
      if (c > 3) c = c - 3;
      return 2'(c);
   endfunction

   always_comb begin
      valid = 1'b0;
      index = 2'd0;
      for (int k = 0; k < 3; k++) begin
         if (!valid && eligible[rr_idx(ptr, k)]) begin
            valid = 1'b1;
            index = rr_idx(ptr, k);
         end
      end
   end
`else
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   always_comb begin
      valid = |eligible;
      index = 2'd0;
      if (eligible[1])      index = 2'd1;
      else if (eligible[2]) index = 2'd2;
      else if (eligible[3]) index = 2'd3;
   end
`endif

endmodule

// File: rtl/ttc_apb_sched18.sv
// APB master sequencer sharing the TTC slave port between a host requester and the interrupt-service
// engine. Build option TTC_SCHED_RR_EN enables round-robin timer selection.
module ttc_apb_sched18
   import ttc_apb_sched18_pkg::*;
#(
   parameter logic [7:0] ISR_BASE   = ISR_BASE_DEF,
   parameter logic [7:0] ISR_STRIDE = ISR_STRIDE_DEF,
   parameter int         HOLDOFF    = HOLDOFF_DEF
)(
   input  logic                pclk18,
   input  logic                p_reset18,
   input  logic                host_req18,
   input  logic                host_write18,
   input  logic [ADDR_W-1:0]   host_addr18,
   input  logic [DATA_W-1:0]   host_wdata18,
   output logic                host_ack18,
   output logic [DATA_W-1:0]   host_rdata18,
   output logic                psel18,
   output logic                penable18,
   output logic                pwrite18,
   output logic [ADDR_W-1:0]   paddr18,
   output logic [DATA_W-1:0]   pwdata18,
   input  logic [DATA_W-1:0]   prdata18,
   input  logic [3:1]          interrupt18,
   output logic                evt_valid18,
   output logic [1:0]          evt_timer18,
   output logic [STATUS_W-1:0] evt_status18,
   output logic                busy18
);

   sched_state_t state_reg, state_next;

   logic [HOLD_W-1:0] holdoff_reg [3:1];
   logic [3:1]        eligible;
   logic              pick_valid;
   logic [1:0]        pick_index;
   logic [1:0]        rr_ptr;
   logic              grant_host, grant_irq;

   logic              prefer_host_reg;
   logic              cur_irq_reg;
   logic [1:0]        cur_timer_reg;

   generate
      for (genvar gi = 1; gi <= 3; gi++) begin : g_timer
         assign eligible[gi] = interrupt18[gi] && (holdoff_reg[gi] == '0);

         // Masks the timer while the TTC clears its clear-on-read interrupt.
         always_ff @(posedge pclk18) begin
            if (p_reset18)
               holdoff_reg[gi] <= '0;
            else if (state_reg == ST_ACCESS && cur_irq_reg && cur_timer_reg == 2'(gi))
               holdoff_reg[gi] <= HOLD_W'(HOLDOFF);
            else if (holdoff_reg[gi] != '0)
               holdoff_reg[gi] <= holdoff_reg[gi] - 1'b1;
         end
      end
   endgenerate

`ifdef TTC_SCHED_RR_EN
   logic [1:0] rr_ptr_reg;

   always_ff @(posedge pclk18) begin
      if (p_reset18)
         rr_ptr_reg <= 2'd1;
      else if (grant_irq)
         rr_ptr_reg <= (pick_index == 2'd3) ? 2'd1 : pick_index + 2'd1;
   end

   assign rr_ptr = rr_ptr_reg;
`else
   assign rr_ptr = 2'd1;
`endif

   ttc_sched_pick18 u_pick (
      .eligible (eligible),
      .ptr      (rr_ptr),
      .valid    (pick_valid),
      .index    (pick_index)
   );

   always_ff @(posedge pclk18) begin
      if (p_reset18)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   // With both sides requesting, prefer_host_reg names the side not granted last.
   always_comb begin
      state_next = state_reg;
      grant_host = 1'b0;
      grant_irq  = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            grant_host = host_req18 && (!pick_valid || prefer_host_reg);
            grant_irq  = pick_valid && (!host_req18 || !prefer_host_reg);
            if (grant_host || grant_irq)
               state_next = ST_SETUP;
         end
         ST_SETUP:  state_next = ST_ACCESS;
         ST_ACCESS: state_next = ST_DONE;
         ST_DONE:   state_next = ST_IDLE;
         default:   state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge pclk18) begin
      if (p_reset18) begin
         psel18          <= 1'b0;
         penable18       <= 1'b0;
         pwrite18        <= 1'b0;
         paddr18         <= '0;
         pwdata18        <= '0;
         host_ack18      <= 1'b0;
         host_rdata18    <= '0;
         evt_valid18     <= 1'b0;
         evt_timer18     <= 2'd0;
         evt_status18    <= '0;
         prefer_host_reg <= 1'b1;
         cur_irq_reg     <= 1'b0;
         cur_timer_reg   <= 2'd0;
      end else begin
         host_ack18  <= 1'b0;
         evt_valid18 <= 1'b0;
         case (state_reg)
            ST_IDLE: begin
               if (grant_host) begin
                  psel18          <= 1'b1;
                  pwrite18        <= host_write18;
                  paddr18         <= host_addr18;
                  pwdata18        <= host_write18 ? host_wdata18 : '0;
                  cur_irq_reg     <= 1'b0;
                  prefer_host_reg <= 1'b0;
               end else if (grant_irq) begin
                  psel18          <= 1'b1;
                  pwrite18        <= 1'b0;
                  paddr18         <= isr_addr(ISR_BASE, ISR_STRIDE, pick_index);
                  pwdata18        <= '0;
                  cur_irq_reg     <= 1'b1;
                  cur_timer_reg   <= pick_index;
                  prefer_host_reg <= 1'b1;
               end
            end
            ST_SETUP: penable18 <= 1'b1;
            ST_ACCESS: begin
               psel18    <= 1'b0;
               penable18 <= 1'b0;
               if (cur_irq_reg) begin
                  evt_valid18  <= 1'b1;
                  evt_timer18  <= cur_timer_reg;
                  evt_status18 <= prdata18[STATUS_W-1:0];
               end else begin
                  host_ack18   <= 1'b1;
                  host_rdata18 <= prdata18;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy18 = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_ttc_apb_sched18.sv
// Directed self-checking bench for ttc_apb_sched18; expectations are hand-derived per scenario.
module tb_ttc_apb_sched18;

   logic        pclk18 = 1'b0;
   logic        p_reset18 = 1'b1;
   logic        host_req18 = 1'b0;
   logic        host_write18 = 1'b0;
   logic [7:0]  host_addr18 = '0;
   logic [31:0] host_wdata18 = '0;
   logic        host_ack18;
   logic [31:0] host_rdata18;
   logic        psel18, penable18, pwrite18;
   logic [7:0]  paddr18;
   logic [31:0] pwdata18;
   logic [31:0] prdata18 = '0;
   logic [3:1]  interrupt18 = '0;
   logic        evt_valid18;
   logic [1:0]  evt_timer18;
   logic [5:0]  evt_status18;
   logic        busy18;

   int tests = 0;
   int fails = 0;

   always #5 pclk18 = ~pclk18;

   ttc_apb_sched18 dut (
      .pclk18       (pclk18),
      .p_reset18    (p_reset18),
      .host_req18   (host_req18),
      .host_write18 (host_write18),
      .host_addr18  (host_addr18),
      .host_wdata18 (host_wdata18),
      .host_ack18   (host_ack18),
      .host_rdata18 (host_rdata18),
      .psel18       (psel18),
      .penable18    (penable18),
      .pwrite18     (pwrite18),
      .paddr18      (paddr18),
      .pwdata18     (pwdata18),
      .prdata18     (prdata18),
      .interrupt18  (interrupt18),
      .evt_valid18  (evt_valid18),
      .evt_timer18  (evt_timer18),
      .evt_status18 (evt_status18),
      .busy18       (busy18)
   );

   task automatic tick();
      @(posedge pclk18);
      #1;
   endtask

   // Advances until an ack or event pulse is visible, bounded to 20 cycles.
   task automatic wait_pulse(output logic ok);
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         tick();
         if (host_ack18 || evt_valid18) ok = 1'b1;
      end
   endtask

   task automatic test_reset();
      p_reset18 = 1'b1;
      tick();
      tick();
      tests++;
      if ({psel18, penable18, pwrite18, host_ack18, evt_valid18, busy18} !== 6'b0) begin
         fails++;
         $display("FAIL reset_ctrl: got %b want 000000",
                  {psel18, penable18, pwrite18, host_ack18, evt_valid18, busy18});
      end
      tests++;
      if ({paddr18, pwdata18, host_rdata18, evt_timer18, evt_status18} !== 80'd0) begin
         fails++;
         $display("FAIL reset_data: got %h want 0",
                  {paddr18, pwdata18, host_rdata18, evt_timer18, evt_status18});
      end
      p_reset18 = 1'b0;
      tick();
      $display("[TB] reset done");
   endtask

   task automatic test_host_write();
      host_req18 = 1'b1; host_write18 = 1'b1; host_addr18 = 8'h0C; host_wdata18 = 32'hA5;
      tick();
      tests++;
      if ({psel18, penable18, pwrite18, busy18} !== 4'b1011 || paddr18 !== 8'h0C || pwdata18 !== 32'hA5) begin
         fails++;
         $display("FAIL wr_setup: got ctl=%b addr=%h wdata=%h want ctl=1011 addr=0c wdata=a5",
                  {psel18, penable18, pwrite18, busy18}, paddr18, pwdata18);
      end
      tick();
      tests++;
      if ({psel18, penable18, pwrite18} !== 3'b111 || paddr18 !== 8'h0C || pwdata18 !== 32'hA5 || host_ack18 !== 1'b0) begin
         fails++;
         $display("FAIL wr_access: got ctl=%b addr=%h wdata=%h ack=%b want ctl=111 addr=0c wdata=a5 ack=0",
                  {psel18, penable18, pwrite18}, paddr18, pwdata18, host_ack18);
      end
      tick();
      tests++;
      if (host_ack18 !== 1'b1 || psel18 !== 1'b0 || penable18 !== 1'b0) begin
         fails++;
         $display("FAIL wr_ack: got ack=%b psel=%b pen=%b want 1 0 0", host_ack18, psel18, penable18);
      end
      host_req18 = 1'b0;
      tick();
      tests++;
      if (host_ack18 !== 1'b0 || busy18 !== 1'b0) begin
         fails++;
         $display("FAIL wr_idle: got ack=%b busy=%b want 0 0", host_ack18, busy18);
      end
      $display("[TB] host write 0c <= a5");
   endtask

   task automatic test_host_read();
      prdata18 = 32'h1234;
      host_req18 = 1'b1; host_write18 = 1'b0; host_addr18 = 8'h18; host_wdata18 = 32'hDEADBEEF;
      tick();
      tests++;
      if (pwrite18 !== 1'b0 || pwdata18 !== 32'h0 || paddr18 !== 8'h18 || psel18 !== 1'b1) begin
         fails++;
         $display("FAIL rd_setup: got pwrite=%b wdata=%h addr=%h psel=%b want 0 0 18 1",
                  pwrite18, pwdata18, paddr18, psel18);
      end
      tick();
      tick();
      tests++;
      if (host_ack18 !== 1'b1 || host_rdata18 !== 32'h1234) begin
         fails++;
         $display("FAIL rd_data: got ack=%b rdata=%h want 1 00001234", host_ack18, host_rdata18);
      end
      host_req18 = 1'b0;
      prdata18 = 32'h0;
      tick();
      tests++;
      if (host_ack18 !== 1'b0 || host_rdata18 !== 32'h1234) begin
         fails++;
         $display("FAIL rd_hold: got ack=%b rdata=%h want 0 00001234", host_ack18, host_rdata18);
      end
      $display("[TB] host read 18 -> %h", host_rdata18);
   endtask

   task automatic test_host_drop();
      host_req18 = 1'b1; host_write18 = 1'b1; host_addr18 = 8'h10; host_wdata18 = 32'h5;
      tick();
      host_req18 = 1'b0;
      tick();
      tick();
      tests++;
      if (host_ack18 !== 1'b1) begin
         fails++;
         $display("FAIL drop_ack: got %b want 1", host_ack18);
      end
      tick();
      tick();
      tests++;
      if (busy18 !== 1'b0 || psel18 !== 1'b0) begin
         fails++;
         $display("FAIL drop_regrant: got busy=%b psel=%b want 0 0", busy18, psel18);
      end
      $display("[TB] host request dropped after grant");
   endtask

   task automatic test_irq();
      logic ok;
      prdata18 = 32'hABCD0041;
      interrupt18 = 3'b010;
      tick();
      tests++;
      if (psel18 !== 1'b1 || pwrite18 !== 1'b0 || paddr18 !== 8'h58 || pwdata18 !== 32'h0) begin
         fails++;
         $display("FAIL irq_setup: got psel=%b pwrite=%b addr=%h wdata=%h want 1 0 58 0",
                  psel18, pwrite18, paddr18, pwdata18);
      end
      tick();
      tick();
      tests++;
      if (evt_valid18 !== 1'b1 || evt_timer18 !== 2'd2 || evt_status18 !== 6'h01 || host_ack18 !== 1'b0) begin
         fails++;
         $display("FAIL irq_evt: got v=%b t=%0d s=%h ack=%b want 1 2 01 0",
                  evt_valid18, evt_timer18, evt_status18, host_ack18);
      end
      tick();
      tick();
      tests++;
      if (busy18 !== 1'b0) begin
         fails++;
         $display("FAIL irq_holdoff: got busy=%b want 0", busy18);
      end
      tick();
      tests++;
      if (busy18 !== 1'b1 || paddr18 !== 8'h58) begin
         fails++;
         $display("FAIL irq_reservice: got busy=%b addr=%h want 1 58", busy18, paddr18);
      end
      interrupt18 = 3'b000;
      prdata18 = 32'h000000FE;
      wait_pulse(ok);
      tests++;
      if (ok !== 1'b1 || evt_valid18 !== 1'b1 || evt_timer18 !== 2'd2 || evt_status18 !== 6'h3E) begin
         fails++;
         $display("FAIL irq_drop_evt: got ok=%b v=%b t=%0d s=%h want 1 1 2 3e",
                  ok, evt_valid18, evt_timer18, evt_status18);
      end
      tick();
      tick();
      tests++;
      if (busy18 !== 1'b0 || evt_status18 !== 6'h3E) begin
         fails++;
         $display("FAIL irq_quiet: got busy=%b s=%h want 0 3e", busy18, evt_status18);
      end
      $display("[TB] irq timer 2 serviced twice");
   endtask

   task automatic test_back_to_back();
      logic       ok;
      logic [3:0] exp_host;
      exp_host = 4'b0101;
      prdata18 = 32'h7;
      host_req18 = 1'b1; host_write18 = 1'b0; host_addr18 = 8'h20;
      interrupt18 = 3'b001;
      for (int k = 0; k < 4; k++) begin
         wait_pulse(ok);
         tests++;
         if (ok !== 1'b1 || host_ack18 !== exp_host[k] || evt_valid18 === exp_host[k] ||
             (!exp_host[k] && (evt_timer18 !== 2'd1 || evt_status18 !== 6'h07))) begin
            fails++;
            $display("FAIL arb_%0d: got ok=%b ack=%b evt=%b t=%0d s=%h want ack=%b evt=%b t=1 s=07",
                     k, ok, host_ack18, evt_valid18, evt_timer18, evt_status18, exp_host[k], !exp_host[k]);
         end
         $display("[TB] arb grant %0d: %s", k, host_ack18 ? "host" : "irq");
      end
      host_req18 = 1'b0;
      interrupt18 = 3'b000;
      tick();
      tick();
      tests++;
      if (busy18 !== 1'b0) begin
         fails++;
         $display("FAIL arb_idle: got busy=%b want 0", busy18);
      end
   endtask

   task automatic test_timer_pick();
      logic       ok;
      logic [1:0] exp_t [4];
`ifdef TTC_SCHED_RR_EN
      exp_t = '{2'd1, 2'd2, 2'd3, 2'd1};
`else
      exp_t = '{2'd1, 2'd2, 2'd1, 2'd2};
`endif
      p_reset18 = 1'b1;
      tick();
      p_reset18 = 1'b0;
      prdata18 = 32'h15;
      interrupt18 = 3'b111;
      for (int k = 0; k < 4; k++) begin
         wait_pulse(ok);
         tests++;
         if (ok !== 1'b1 || evt_valid18 !== 1'b1 || evt_timer18 !== exp_t[k] || evt_status18 !== 6'h15) begin
            fails++;
            $display("FAIL pick_%0d: got ok=%b v=%b t=%0d s=%h want 1 1 %0d 15",
                     k, ok, evt_valid18, evt_timer18, evt_status18, exp_t[k]);
         end
         $display("[TB] pick %0d: timer %0d", k, evt_timer18);
      end
      interrupt18 = 3'b000;
      tick();
      tick();
   endtask

   task automatic test_reset_mid();
      host_req18 = 1'b1; host_write18 = 1'b1; host_addr18 = 8'h0C; host_wdata18 = 32'h77;
      tick();
      tick();
      tests++;
      if (penable18 !== 1'b1) begin
         fails++;
         $display("FAIL rst_mid_access: got penable=%b want 1", penable18);
      end
      p_reset18 = 1'b1;
      host_req18 = 1'b0;
      tick();
      tests++;
      if ({psel18, penable18, host_ack18, evt_valid18, busy18} !== 5'b0) begin
         fails++;
         $display("FAIL rst_mid: got %b want 00000", {psel18, penable18, host_ack18, evt_valid18, busy18});
      end
      p_reset18 = 1'b0;
      tick();
      tests++;
      if (host_ack18 !== 1'b0 || busy18 !== 1'b0) begin
         fails++;
         $display("FAIL rst_mid_after: got ack=%b busy=%b want 0 0", host_ack18, busy18);
      end
      $display("[TB] reset during access");
   endtask

   initial begin
      test_reset();
      test_host_write();
      test_host_read();
      test_host_drop();
      test_irq();
      test_back_to_back();
      test_timer_pick();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
